// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline-side hazard tracking logic.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;
    localparam int CPU_REG_AW = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_AW-1:0] regbits_t;

    // Next-PC source class; also used as the shadow tag class.
    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcsrc_t;

    // A bubble in IF/ID is an all-zero word (sll r0,r0,0).
    localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline stage of shadow tags: destination register and PC-source class.
// Flush has priority over load; nothing moves while en is low.
module stage_tag_reg
    import cpu_types_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic [REG_AW-1:0] d_dest,
    input  logic [1:0]        d_cls,
    output logic [REG_AW-1:0] q_dest,
    output logic [1:0]        q_cls
);

    logic [REG_AW-1:0] r_dest;
    logic [1:0]        r_cls;

    // Tag register: reset, then flush-to-empty, then load on advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dest <= '0;
            r_cls  <= PC_SEQ;
        end else if (en) begin
            if (flush) begin
                r_dest <= '0;
                r_cls  <= PC_SEQ;
            end else begin
                r_dest <= d_dest;
                r_cls  <= d_cls;
            end
        end
    end

    assign q_dest = r_dest;
    assign q_cls  = r_cls;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Pipeline-side companion of the hazard unit: owns the PC, the IF/ID latch and
// the ID/EX and EX/MEM shadow tags, and applies the unit's stall/flush decisions.
// Nothing moves unless the fetch hit and no data access is outstanding, so a
// flush raised during a memory stall only takes effect on the first advance.
module hazard_pipe_tracker
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32,
    parameter int          REG_AW  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmem_req,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] branch_target,
    input  logic [WORD_W-1:0] jump_target,
    input  logic [WORD_W-1:0] jr_target,
    input  logic [1:0]        PCSrc_sel,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [1:0]        id_tmpPC,
    input  logic              stall_IFID,
    input  logic              stall_PC,
    input  logic              flush_IFID,
    input  logic              flush_IDEX,
    output logic [WORD_W-1:0] imemaddr,
    output logic              imemREN,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [1:0]        tmpPC,
    output logic [1:0]        PCSrc,
    output logic [1:0]        IDEX_tmpPC,
    output logic [1:0]        EXMEM_tmpPC,
    output logic [REG_AW-1:0] destEX,
    output logic [REG_AW-1:0] destMEM
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_ifid_instr;
    logic [WORD_W-1:0] r_ifid_npc;

    logic              w_adv;
    logic [WORD_W-1:0] w_pc_plus4;
    logic [WORD_W-1:0] w_pc_next;

    assign w_adv      = ihit & ~(dmem_req & ~dhit);
    assign w_pc_plus4 = r_pc + WORD_W'(4);

    // Next-PC selection; sequential fetch is the default path.
    always_comb begin
        w_pc_next = w_pc_plus4;
        case (pcsrc_t'(PCSrc_sel))
            PC_SEQ:  w_pc_next = w_pc_plus4;
            PC_BR:   w_pc_next = branch_target;
            PC_J:    w_pc_next = jump_target;
            PC_JR:   w_pc_next = jr_target;
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    // PC register: hold on memory stall or hazard stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= WORD_W'(PC_INIT);
        end else if (w_adv && !stall_PC) begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID latch: flush beats stall beats load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ifid_instr <= WORD_W'(NOP_INSTR);
            r_ifid_npc   <= '0;
        end else if (w_adv) begin
            if (flush_IFID) begin
                r_ifid_instr <= WORD_W'(NOP_INSTR);
                r_ifid_npc   <= '0;
            end else if (!stall_IFID) begin
                r_ifid_instr <= imemload;
                r_ifid_npc   <= w_pc_plus4;
            end
        end
    end

    // ID/EX tags ignore stall_IFID: a stalled decode still injects a bubble via flush_IDEX.
    stage_tag_reg #(.REG_AW(REG_AW)) u_idex (
        .CLK    (CLK),
        .RST    (RST),
        .en     (w_adv),
        .flush  (flush_IDEX),
        .d_dest (id_dest),
        .d_cls  (id_tmpPC),
        .q_dest (destEX),
        .q_cls  (IDEX_tmpPC)
    );

    stage_tag_reg #(.REG_AW(REG_AW)) u_exmem (
        .CLK    (CLK),
        .RST    (RST),
        .en     (w_adv),
        .flush  (1'b0),
        .d_dest (destEX),
        .d_cls  (IDEX_tmpPC),
        .q_dest (destMEM),
        .q_cls  (EXMEM_tmpPC)
    );

    assign imemaddr   = r_pc;
    assign imemREN    = ~RST;
    assign ifid_instr = r_ifid_instr;
    assign ifid_npc   = r_ifid_npc;
    assign rs         = r_ifid_instr[25:21];
    assign rt         = r_ifid_instr[20:16];
    assign tmpPC      = id_tmpPC;
    assign PCSrc      = PCSrc_sel;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Scoreboard bench: each applied vector pushes the expected post-edge view of
// the tracker; a monitor pops one entry after every edge and compares.
module tb_hazard_pipe_tracker;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, dmem_req;
    logic [31:0] imemload, branch_target, jump_target, jr_target;
    logic [1:0]  PCSrc_sel, id_tmpPC;
    logic [4:0]  id_dest;
    logic        stall_IFID, stall_PC, flush_IFID, flush_IDEX;

    logic [31:0] imemaddr, ifid_instr, ifid_npc;
    logic        imemREN;
    logic [4:0]  rs, rt, destEX, destMEM;
    logic [1:0]  tmpPC, PCSrc, IDEX_tmpPC, EXMEM_tmpPC;

    hazard_pipe_tracker dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .imemload(imemload), .branch_target(branch_target), .jump_target(jump_target),
        .jr_target(jr_target), .PCSrc_sel(PCSrc_sel), .id_dest(id_dest), .id_tmpPC(id_tmpPC),
        .stall_IFID(stall_IFID), .stall_PC(stall_PC), .flush_IFID(flush_IFID),
        .flush_IDEX(flush_IDEX), .imemaddr(imemaddr), .imemREN(imemREN),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .rs(rs), .rt(rt), .tmpPC(tmpPC),
        .PCSrc(PCSrc), .IDEX_tmpPC(IDEX_tmpPC), .EXMEM_tmpPC(EXMEM_tmpPC),
        .destEX(destEX), .destMEM(destMEM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc, instr, npc;
        logic [4:0]  dest_ex, dest_mem;
        logic [1:0]  cls_ex, cls_mem, tmp, sel;
        logic        ren;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: architectural PC, IF/ID contents, and a two-slot tag pipe
    // (slot 0 = ID/EX, slot 1 = EX/MEM).
    logic [31:0] m_pc, m_instr, m_npc;
    logic [4:0]  m_dest[2];
    logic [1:0]  m_cls[2];

    task automatic commit();
        exp_t        e;
        logic [31:0] src[4];
        bit          moves;
        if (RST) begin
            m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
            m_dest = '{5'd0, 5'd0}; m_cls = '{2'd0, 2'd0};
        end else begin
            moves = ihit && !(dmem_req && !dhit);
            if (moves) begin
                src = '{m_pc + 32'd4, branch_target, jump_target, jr_target};
                m_dest[1] = m_dest[0];
                m_cls[1]  = m_cls[0];
                m_dest[0] = flush_IDEX ? 5'd0 : id_dest;
                m_cls[0]  = flush_IDEX ? 2'd0 : id_tmpPC;
                if (flush_IFID) begin
                    m_instr = 32'h0; m_npc = 32'h0;
                end else if (!stall_IFID) begin
                    m_instr = imemload; m_npc = m_pc + 32'd4;
                end
                if (!stall_PC) m_pc = src[PCSrc_sel];
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.npc = m_npc;
        e.dest_ex = m_dest[0]; e.dest_mem = m_dest[1];
        e.cls_ex = m_cls[0]; e.cls_mem = m_cls[1];
        e.tmp = id_tmpPC; e.sel = PCSrc_sel; e.ren = !RST;
        exp_q.push_back(e);
    endtask

    // Start a new cycle with quiet controls and fresh random data.
    task automatic nxt();
        @(negedge CLK);
        RST = 0; ihit = 1; dhit = 0; dmem_req = 0;
        stall_IFID = 0; stall_PC = 0; flush_IFID = 0; flush_IDEX = 0;
        PCSrc_sel = 2'd0;
        imemload = $urandom; branch_target = $urandom; jump_target = $urandom;
        jr_target = $urandom; id_dest = 5'($urandom); id_tmpPC = 2'($urandom);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge after stimulus has begun produces one observable state.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("imemaddr",    imemaddr,    e.pc);
            chk("ifid_instr",  ifid_instr,  e.instr);
            chk("ifid_npc",    ifid_npc,    e.npc);
            chk("rs",          32'(rs),     32'(e.instr[25:21]));
            chk("rt",          32'(rt),     32'(e.instr[20:16]));
            chk("destEX",      32'(destEX), 32'(e.dest_ex));
            chk("destMEM",     32'(destMEM), 32'(e.dest_mem));
            chk("IDEX_tmpPC",  32'(IDEX_tmpPC), 32'(e.cls_ex));
            chk("EXMEM_tmpPC", 32'(EXMEM_tmpPC), 32'(e.cls_mem));
            chk("tmpPC",       32'(tmpPC),  32'(e.tmp));
            chk("PCSrc",       32'(PCSrc),  32'(e.sel));
            chk("imemREN",     32'(imemREN), 32'(e.ren));
        end
    end

    initial begin
        RST = 1; ihit = 1; dhit = 0; dmem_req = 0;
        stall_IFID = 0; stall_PC = 0; flush_IFID = 0; flush_IDEX = 0;
        PCSrc_sel = 0; imemload = 0; branch_target = 0; jump_target = 0; jr_target = 0;
        id_dest = 0; id_tmpPC = 0;

        // Reset held two cycles, then free-running sequential fetch.
        repeat (2) begin nxt(); RST = 1; commit(); end
        repeat (3) begin nxt(); commit(); end

        // Data-memory stall freezes everything; dhit releases exactly one advance.
        repeat (3) begin nxt(); dmem_req = 1; flush_IFID = 1; flush_IDEX = 1; stall_PC = 1; commit(); end
        nxt(); dmem_req = 1; dhit = 1; commit();
        nxt(); ihit = 0; commit();

        // Destination tag walks ID/EX then EX/MEM.
        nxt(); id_dest = 5'd8; commit();
        nxt(); id_dest = 5'd3; commit();
        nxt(); commit();

        // Load-use stall with ID/EX bubble.
        nxt(); id_dest = 5'd12; commit();
        nxt(); stall_PC = 1; stall_IFID = 1; flush_IDEX = 1; imemload = 32'hDEAD_BEEF; commit();

        // Taken branch with IF/ID flush, then JR, then a combined stall+flush.
        nxt(); PCSrc_sel = 2'd1; branch_target = 32'h40; flush_IFID = 1; commit();
        nxt(); PCSrc_sel = 2'd3; jr_target = 32'h100; commit();
        nxt(); stall_PC = 1; flush_IFID = 1; commit();
        nxt(); PCSrc_sel = 2'd2; commit();

        // PC wrap at the top of the address space.
        nxt(); PCSrc_sel = 2'd3; jr_target = 32'hFFFF_FFFC; commit();
        nxt(); commit();
        nxt(); commit();

        // Reset taking priority over an outstanding memory stall.
        nxt(); dmem_req = 1; commit();
        nxt(); dmem_req = 1; RST = 1; commit();
        nxt(); commit();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            nxt();
            RST        = ($urandom_range(0, 49) == 0);
            ihit       = ($urandom_range(0, 7) != 0);
            dmem_req   = ($urandom_range(0, 3) == 0);
            dhit       = $urandom_range(0, 1) == 1;
            stall_PC   = ($urandom_range(0, 5) == 0);
            stall_IFID = ($urandom_range(0, 5) == 0);
            flush_IFID = ($urandom_range(0, 5) == 0);
            flush_IDEX = ($urandom_range(0, 5) == 0);
            PCSrc_sel  = 2'($urandom);
            commit();
        end

        nxt(); commit();
        repeat (3) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
